fpu_op_sequencer: RTL
=====================

Name: fpu_op_sequencer

Overview:
Sequences one floating-point operation from the CPU execute stage into the stb/ack-handshaked FP adder unit and returns the result to the pipeline. The CPU side is a valid/ready request port with a one-cycle response pulse. The unit side drives the adder's three-phase protocol: send A, send B, collect Z. It handles fadd/fsub (sign flip of B for fsub), flags unsupported ops, and reports per-operation latency.

Parameters:
LAT_W, 16, width of the latency counter; saturates at all-ones.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  CPU request valid
req_ready  out  1  sequencer can accept a request (high only in IDLE)
req_op  in  4  0000 fadd, 0001 fsub; all other codes illegal
req_a  in  32  operand 1 (IEEE-754 single)
req_b  in  32  operand 2
resp_valid  out  1  one-cycle result pulse
resp_data  out  32  result; 0 when illegal
resp_illegal  out  1  qualifies resp_valid; op unsupported
resp_latency  out  LAT_W  cycles from SEND_A entry to Z handshake, inclusive
busy  out  1  state != IDLE
u_a  out  32  unit input_a
u_a_stb  out  1  unit input_a_stb
u_a_ack  in  1  unit input_a_ack
u_b  out  32  unit input_b
u_b_stb  out  1  unit input_b_stb
u_b_ack  in  1  unit input_b_ack
u_z  in  32  unit output_z
u_z_stb  in  1  unit output_z_stb
u_z_ack  out  1  unit output_z_ack

Behaviour:
- Reset (async, any state): state=IDLE; resp_valid, resp_illegal, all stb/ack outputs = 0; resp_data, u_a, u_b, resp_latency = 0. The unit shares rst, so an aborted operation leaves no residue.
- Handshake rule, both sides: a transfer occurs at a rising edge where stb and ack are both 1.
- States:
  - IDLE: req_ready=1. On req_valid, capture operands and go to SEND_A, or go to DONE if op is illegal. Capture: u_a=req_a; u_b=req_b, or {~req_b[31], req_b[30:0]} when op=0001.
  - SEND_A: u_a_stb=1. On u_a_ack, go to SEND_B.
  - SEND_B: u_b_stb=1. On u_b_ack, go to WAIT_Z.
  - WAIT_Z: u_z_ack=1. On u_z_stb, capture resp_data=u_z and go to DONE.
  - DONE: resp_valid=1 for exactly one cycle, then IDLE.
- Strobe/ack timing: stb/ack outputs decode from the state register only, with no combinational path from inputs. u_a_stb holds until acked; u_a and u_b stay stable from capture until the next accept.
- Ignored inputs: acks or u_z_stb arriving outside their state are ignored. req_valid outside IDLE is not accepted; req_ready=0, and the CPU must hold the request.
- Best-case latency: accept at cycle N → A handshake N+1 → B handshake N+2 → Z handshake at the earliest N+3 → resp_valid N+4. The next accept is possible at N+5, since IDLE is re-entered then.
- Latency counter:
  - Cleared on accept.
  - Increments every cycle in SEND_A, SEND_B and WAIT_Z, including the Z handshake cycle.
  - Saturates at all-ones.
  - Loads into resp_latency on DONE entry.
- Illegal op:
  - No unit strobes.
  - DONE in the cycle after accept.
  - resp_illegal=1, resp_data=0, resp_latency=0.
  - resp_illegal is cleared on the next accept.
- resp_data, resp_illegal and resp_latency hold their values until the next DONE or reset.

Test Plan:
- fadd 0x3F800000 + 0x40000000, unit acks immediately → u_b=0x40000000; one resp_valid pulse with resp_data=0x40400000; resp_latency=3 at best case.
- fsub 0x40400000 − 0x3F800000 → u_b driven as 0xBF800000; resp_data=0x40000000.
- req_op=0010 → no u_a_stb/u_b_stb ever high; resp_valid the cycle after accept; resp_illegal=1; resp_data=0.
- Unit model delays u_a_ack 3 cycles and u_z_stb 5 cycles → u_a_stb held 4 cycles with u_a stable; req_ready=0 and busy=1 throughout; resp_latency equals the measured cycle count.
- Two back-to-back requests with req_valid held high → second accepted only in the cycle after the first resp_valid; results returned in order.
- Assert rst while in WAIT_Z → all outputs 0 immediately; state IDLE; a subsequent fadd 1.0+1.0 returns 0x40000000.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
// Sequences one fadd/fsub from the CPU execute stage through the stb/ack FP adder
// (send A, send B, collect Z) and returns a one-cycle result pulse with latency.
module fpu_op_sequencer #(
    parameter int LAT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic             resp_illegal,
    output logic [LAT_W-1:0] resp_latency,
    output logic             busy,
    output logic [31:0]      u_a,
    output logic             u_a_stb,
    input  logic             u_a_ack,
    output logic [31:0]      u_b,
    output logic             u_b_stb,
    input  logic             u_b_ack,
    input  logic [31:0]      u_z,
    input  logic             u_z_stb,
    output logic             u_z_ack
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_A,
        S_SEND_B,
        S_WAIT_Z,
        S_DONE
    } state_t;

    localparam logic [3:0]       OP_FADD = 4'b0000;
    localparam logic [3:0]       OP_FSUB = 4'b0001;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    state_t           state_reg, state_next;
    logic [31:0]      u_a_reg, u_a_next;
    logic [31:0]      u_b_reg, u_b_next;
    logic [31:0]      resp_data_reg, resp_data_next;
    logic             resp_illegal_reg, resp_illegal_next;
    logic [LAT_W-1:0] resp_latency_reg, resp_latency_next;
    logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
    logic [LAT_W-1:0] lat_inc;
    logic [31:0]      b_capture;
    logic             op_legal;
    logic             accept;
    logic             z_hs;
    logic             in_flight;

    assign op_legal  = (req_op == OP_FADD) || (req_op == OP_FSUB);
    assign accept    = (state_reg == S_IDLE) && req_valid;
    assign z_hs      = (state_reg == S_WAIT_Z) && u_z_stb;
    assign in_flight = (state_reg == S_SEND_A) || (state_reg == S_SEND_B) ||
                       (state_reg == S_WAIT_Z);

    // fsub is executed on the adder by negating operand B
    assign b_capture = {req_b[31] ^ (req_op == OP_FSUB), req_b[30:0]};

    // Saturating increment so a stalled unit cannot wrap the reported latency
    assign lat_inc = (lat_cnt_reg == LAT_MAX) ? lat_cnt_reg : lat_cnt_reg + LAT_W'(1);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_valid) begin
                    state_next = op_legal ? S_SEND_A : S_DONE;
                end
            end
            S_SEND_A: begin
                if (u_a_ack) begin
                    state_next = S_SEND_B;
                end
            end
            S_SEND_B: begin
                if (u_b_ack) begin
                    state_next = S_WAIT_Z;
                end
            end
            S_WAIT_Z: begin
                if (u_z_stb) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Handshake outputs decode from the state register only
    always_comb begin
        req_ready  = 1'b0;
        busy       = 1'b1;
        u_a_stb    = 1'b0;
        u_b_stb    = 1'b0;
        u_z_ack    = 1'b0;
        resp_valid = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            S_SEND_A: u_a_stb    = 1'b1;
            S_SEND_B: u_b_stb    = 1'b1;
            S_WAIT_Z: u_z_ack    = 1'b1;
            S_DONE:   resp_valid = 1'b1;
            default: begin
                busy = 1'b1;
            end
        endcase
    end

    always_comb begin
        u_a_next          = u_a_reg;
        u_b_next          = u_b_reg;
        resp_data_next    = resp_data_reg;
        resp_illegal_next = resp_illegal_reg;
        resp_latency_next = resp_latency_reg;
        lat_cnt_next      = lat_cnt_reg;

        if (accept) begin
            u_a_next          = req_a;
            u_b_next          = b_capture;
            lat_cnt_next      = '0;
            resp_illegal_next = !op_legal;
            // Illegal ops go straight to DONE, so their result is loaded here
            if (!op_legal) begin
                resp_data_next    = '0;
                resp_latency_next = '0;
            end
        end

        if (in_flight) begin
            lat_cnt_next = lat_inc;
        end

        if (z_hs) begin
            resp_data_next    = u_z;
            resp_latency_next = lat_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            u_a_reg          <= '0;
            u_b_reg          <= '0;
            resp_data_reg    <= '0;
            resp_illegal_reg <= 1'b0;
            resp_latency_reg <= '0;
            lat_cnt_reg      <= '0;
        end else begin
            state_reg        <= state_next;
            u_a_reg          <= u_a_next;
            u_b_reg          <= u_b_next;
            resp_data_reg    <= resp_data_next;
            resp_illegal_reg <= resp_illegal_next;
            resp_latency_reg <= resp_latency_next;
            lat_cnt_reg      <= lat_cnt_next;
        end
    end

    assign u_a          = u_a_reg;
    assign u_b          = u_b_reg;
    assign resp_data    = resp_data_reg;
    assign resp_illegal = resp_illegal_reg;
    assign resp_latency = resp_latency_reg;

endmodule
